// File: rtl/melody_sequencer.sv
// Event-driven tune player feeding Buzzer.music_scale from a constant note table.
// Optional looping background tune when MELODY_BGM_LOOP_EN is defined.
module melody_sequencer #(
  parameter int BEAT_TICKS = 6_250_000,
  parameter int GAP_TICKS  = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load_done,
  input  logic       i_perfect,
  input  logic       i_gameover,
  output logic [5:0] music_scale,
  output logic       o_busy,
  output logic [1:0] o_tune_id,
  output logic       o_done
);

  localparam int CW = $clog2(15 * BEAT_TICKS + 1);

  localparam logic [1:0] TUNE_BGM      = 2'd0;
  localparam logic [1:0] TUNE_LAND     = 2'd1;
  localparam logic [1:0] TUNE_PERFECT  = 2'd2;
  localparam logic [1:0] TUNE_GAMEOVER = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NOTE,
    S_GAP
  } state_t;

  state_t        state, state_n;
  logic [1:0]    tune, tune_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done, done_n;

  logic          gover_q;
  logic          req_valid, req_valid_n;
  logic [1:0]    req_id, req_id_n;

  logic [5:0]    cur_scale;
  logic [3:0]    cur_dur;
  logic [3:0]    nxt_dur;
  logic [CW-1:0] note_len;

  // Entry = {scale[5:0], dur[3:0]}; dur of 0 marks the end of a tune.
  function automatic logic [9:0] entry(input logic [1:0] t, input logic [2:0] i);
    logic [9:0] e;
    e = '0;
    case (t)
      TUNE_LAND: begin
        case (i)
          3'd0: e = {6'd3, 4'd2};
          3'd1: e = {6'd5, 4'd2};
          default: e = '0;
        endcase
      end
      TUNE_PERFECT: begin
        case (i)
          3'd0: e = {6'd1, 4'd1};
          3'd1: e = {6'd3, 4'd1};
          3'd2: e = {6'd5, 4'd1};
          3'd3: e = {6'd8, 4'd3};
          default: e = '0;
        endcase
      end
      TUNE_GAMEOVER: begin
        case (i)
          3'd0: e = {6'd5, 4'd2};
          3'd1: e = {6'd4, 4'd2};
          3'd2: e = {6'd3, 4'd2};
          3'd3: e = {6'd2, 4'd2};
          3'd4: e = {6'd1, 4'd4};
          default: e = '0;
        endcase
      end
      default: begin
`ifdef MELODY_BGM_LOOP_EN
        case (i)
          3'd0: e = {6'd1, 4'd2};
          3'd1: e = {6'd1, 4'd2};
          3'd2: e = {6'd5, 4'd2};
          3'd3: e = {6'd5, 4'd2};
          3'd4: e = {6'd6, 4'd2};
          3'd5: e = {6'd6, 4'd2};
          3'd6: e = {6'd5, 4'd4};
          default: e = '0;
        endcase
`else
        e = '0;
`endif
      end
    endcase
    return e;
  endfunction

  function automatic logic [5:0] scale_at(input logic [1:0] t, input logic [2:0] i);
    return 6'(entry(t, i) >> 4);
  endfunction

  function automatic logic [3:0] dur_at(input logic [1:0] t, input logic [2:0] i);
    return 4'(entry(t, i));
  endfunction

  // Request decode; landings are masked for as long as game-over is asserted.
  always_comb begin
    req_valid_n = 1'b0;
    req_id_n    = TUNE_BGM;
    if (i_gameover && !gover_q) begin
      req_valid_n = 1'b1;
      req_id_n    = TUNE_GAMEOVER;
    end else if (!i_gameover && i_load_done) begin
      req_valid_n = 1'b1;
      req_id_n    = i_perfect ? TUNE_PERFECT : TUNE_LAND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gover_q   <= 1'b0;
      req_valid <= 1'b0;
      req_id    <= '0;
      state     <= S_IDLE;
      tune      <= '0;
      idx       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      gover_q   <= i_gameover;
      req_valid <= req_valid_n;
      req_id    <= req_id_n;
      state     <= state_n;
      tune      <= tune_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      done      <= done_n;
    end
  end

  always_comb begin
    cur_scale = scale_at(tune, idx);
    cur_dur   = dur_at(tune, idx);
    nxt_dur   = dur_at(tune, idx + 3'd1);
    note_len  = CW'(cur_dur) * CW'(BEAT_TICKS);

    state_n = state;
    tune_n  = tune;
    idx_n   = idx;
    cnt_n   = cnt + 1'b1;
    done_n  = 1'b0;

    // An accepted request wins even over a natural finish in the same cycle.
    if (req_valid && (state == S_IDLE || req_id >= tune)) begin
      state_n = S_NOTE;
      tune_n  = req_id;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_n = '0;
`ifdef MELODY_BGM_LOOP_EN
          if (!i_gameover) begin
            state_n = S_NOTE;
            tune_n  = TUNE_BGM;
            idx_n   = '0;
          end
`endif
        end
        S_NOTE: begin
          if (cnt == note_len - CW'(1)) begin
            cnt_n = '0;
            if (nxt_dur != 4'd0) begin
              state_n = S_GAP;
              idx_n   = idx + 3'd1;
            end else if (tune == TUNE_BGM) begin
              state_n = S_GAP;
              idx_n   = '0;
            end else begin
              state_n = S_IDLE;
              tune_n  = TUNE_BGM;
              idx_n   = '0;
              done_n  = 1'b1;
            end
          end
        end
        S_GAP: begin
          if (cnt == CW'(GAP_TICKS - 1)) begin
            state_n = S_NOTE;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    music_scale = (state == S_NOTE) ? cur_scale : '0;
    o_busy      = (state != S_IDLE) && (tune != TUNE_BGM);
    o_tune_id   = o_busy ? tune : TUNE_BGM;
    o_done      = done;
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: the stimulus side expands each accepted tune
// into its per-cycle output waveform; a monitor pops and compares one entry per cycle.
module tb_melody_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_load_done = 1'b0;
  logic       i_perfect = 1'b0;
  logic       i_gameover = 1'b0;
  logic [5:0] music_scale;
  logic       o_busy;
  logic [1:0] o_tune_id;
  logic       o_done;

  melody_sequencer #(.BEAT_TICKS(BEAT), .GAP_TICKS(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .i_load_done(i_load_done),
    .i_perfect(i_perfect),
    .i_gameover(i_gameover),
    .music_scale(music_scale),
    .o_busy(o_busy),
    .o_tune_id(o_tune_id),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] sc;
    logic       busy;
    logic [1:0] id;
    logic       done;
  } exp_t;

  localparam exp_t IDLE_OUT = '{sc: 6'd0, busy: 1'b0, id: 2'd0, done: 1'b0};

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   go_prev = 1'b0;
  bit   stop_mon = 1'b0;
  bit   sim_done = 1'b0;

  // Full output waveform of a tune: notes, gaps between notes, then one done cycle.
  function automatic void push_tune(input int id);
    int   sc[$];
    int   du[$];
    exp_t e;
    case (id)
      1: begin sc = '{3, 5};          du = '{2, 2};          end
      2: begin sc = '{1, 3, 5, 8};    du = '{1, 1, 1, 3};    end
      3: begin sc = '{5, 4, 3, 2, 1}; du = '{2, 2, 2, 2, 4}; end
      default: begin end
    endcase
    for (int k = 0; k < sc.size(); k++) begin
      for (int c = 0; c < du[k] * BEAT; c++) begin
        e.sc = 6'(sc[k]); e.busy = 1'b1; e.id = 2'(id); e.done = 1'b0;
        q.push_back(e);
      end
      if (k < sc.size() - 1) begin
        for (int c = 0; c < GAP; c++) begin
          e.sc = 6'd0; e.busy = 1'b1; e.id = 2'(id); e.done = 1'b0;
          q.push_back(e);
        end
      end
    end
    e.sc = 6'd0; e.busy = 1'b0; e.id = 2'd0; e.done = 1'b1;
    q.push_back(e);
  endfunction

  // One cycle of stimulus, applied at the falling edge; q[0] is the output after the next rise.
  task automatic step(input bit r, input bit ld, input bit pf, input bit go);
    int   rid;
    exp_t front;
    @(negedge clk);
    rst = r; i_load_done = ld; i_perfect = pf; i_gameover = go;
    if (r) begin
      q.delete();
      go_prev = 1'b0;
    end else begin
      rid = 0;
      if (go && !go_prev) rid = 3;
      else if (!go && ld) rid = pf ? 2 : 1;
      go_prev = go;
      if (rid != 0) begin
        front = (q.size() > 0) ? q[0] : IDLE_OUT;
        if (!front.busy || rid >= int'(front.id)) begin
          if (q.size() == 0) q.push_back(IDLE_OUT);
          while (q.size() > 1) void'(q.pop_back());
          push_tune(rid);
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit go);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, go);
  endtask

  // Monitor: compares every cycle's outputs against the scoreboard head.
  initial begin
    exp_t e;
    exp_t got;
    @(posedge clk);
    while (!stop_mon) begin
      #1;
      cyc++;
      e = (q.size() > 0) ? q.pop_front() : IDLE_OUT;
      got.sc = music_scale; got.busy = o_busy; got.id = o_tune_id; got.done = o_done;
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL out cyc=%0d got scale=%0d busy=%0b id=%0d done=%0b exp scale=%0d busy=%0b id=%0d done=%0b",
                 cyc, got.sc, got.busy, got.id, got.done, e.sc, e.busy, e.id, e.done);
      end
      @(posedge clk);
    end
  end

  initial begin
    #2_000_000;
    if (!sim_done) begin
      n_bad++;
      $display("FAIL timeout: stimulus did not complete within the wait limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    bit go;
    bit r;
    bit ld;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (music_scale !== 6'd0 || o_busy !== 1'b0 || o_tune_id !== 2'd0 || o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset state: scale=%0d busy=%0b id=%0d done=%0b",
               music_scale, o_busy, o_tune_id, o_done);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);          // LAND
    idle(24, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);          // PERFECT
    idle(40, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);          // perfect without load: ignored
    idle(4, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);          // LAND, then GAMEOVER preempts
    idle(4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);          // landing during game-over: ignored
    idle(60, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);          // still silent after GAMEOVER
    idle(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);          // rise + load together: GAMEOVER only
    idle(6, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);          // reset mid-note
    idle(3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);          // PERFECT then LAND 3 cycles later (lower, ignored)
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(30, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);          // LAND preempted by PERFECT
    idle(5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(40, 1'b0);

    go = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (go) go = ($urandom_range(0, 39) != 0);
      else    go = ($urandom_range(0, 149) == 0);
      r  = ($urandom_range(0, 399) == 0);
      ld = ($urandom_range(0, 11) == 0);
      step(r, ld, 1'($urandom_range(0, 1)), go);
    end
    idle(5, 1'b1);
    idle(120, 1'b0);
    sim_done = 1'b1;
    stop_mon = 1'b1;
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
